// File: rtl/core_pkg.sv
// Shared register-file types: address/data widths and the write-port arbiter states.
package core_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NREGS      = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {IDLE, HOLD, FORCE} arb_state_t;

    // One-hot register select; r0 is hardwired zero and never tracked.
    function automatic logic [NREGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NREGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        v[0] = 1'b0;
        return v;
    endfunction
endpackage

// File: rtl/regfile_busy_scoreboard.sv
// Busy mask of registers with an outstanding long-latency write; a same-edge set beats a clear.
module regfile_busy_scoreboard
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_addr,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_addr,
    output logic [NREGS-1:0]      o_busy
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;

    assign w_set  = i_set_en ? addr_onehot(i_set_addr) : '0;
    assign w_clr  = i_clr_en ? addr_onehot(i_clr_addr) : '0;
    assign o_busy = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between pipeline writeback (priority) and a
// long-latency unit, with a one-entry skid buffer and a starvation-forced drain.
module regfile_wb_arbiter
    import core_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  pipe_stall,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_addr,
    input  logic [XLEN-1:0]       lu_data,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_addr,
    output logic [NREGS-1:0]      busy_mask,
    output logic [REG_ADDR_W-1:0] rf_wt_addr,
    output logic [XLEN-1:0]       rf_wt_data,
    output logic                  rf_L_S
);
    arb_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [REG_ADDR_W-1:0] r_buf_addr;
    logic [XLEN-1:0]       r_buf_data;
    logic [REG_ADDR_W-1:0] r_wt_addr;
    logic [XLEN-1:0]       r_wt_data;
    logic                  r_ls;

    logic                  w_wb_req;
    logic                  w_lu_keep;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_starved;
    logic                  w_clr_en;
    logic [REG_ADDR_W-1:0] w_clr_addr;

    assign lu_ready   = (r_state == IDLE);
    assign pipe_stall = (r_state == FORCE);
    assign w_wb_req   = wb_valid && (wb_addr != '0);
    // Results for r0 are accepted but never written or buffered.
    assign w_lu_keep  = lu_valid && lu_ready && (lu_addr != '0);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_starved  = (w_cnt_inc == CNT_W'(STARVE_MAX));

    assign rf_wt_addr = r_wt_addr;
    assign rf_wt_data = r_wt_data;
    assign rf_L_S     = r_ls;

    always_comb begin
        w_clr_en   = 1'b0;
        w_clr_addr = lu_addr;
        case (r_state)
            IDLE:  w_clr_en = !w_wb_req && w_lu_keep;
            HOLD: begin
                w_clr_en   = !w_wb_req;
                w_clr_addr = r_buf_addr;
            end
            FORCE: begin
                w_clr_en   = 1'b1;
                w_clr_addr = r_buf_addr;
            end
            default: w_clr_en = 1'b0;
        endcase
    end

    regfile_busy_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (iss_valid),
        .i_set_addr (iss_addr),
        .i_clr_en   (w_clr_en),
        .i_clr_addr (w_clr_addr),
        .o_busy     (busy_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_wt_addr  <= '0;
            r_wt_data  <= '0;
            r_ls       <= 1'b0;
        end else begin
            r_ls <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_wb_req) begin
                        r_wt_addr <= wb_addr;
                        r_wt_data <= wb_data;
                        r_ls      <= 1'b1;
                        if (w_lu_keep) begin
                            r_buf_addr <= lu_addr;
                            r_buf_data <= lu_data;
                            r_cnt      <= CNT_W'(1);
                            r_state    <= (STARVE_MAX == 1) ? FORCE : HOLD;
                        end
                    end else if (w_lu_keep) begin
                        r_wt_addr <= lu_addr;
                        r_wt_data <= lu_data;
                        r_ls      <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_wb_req) begin
                        r_wt_addr <= wb_addr;
                        r_wt_data <= wb_data;
                        r_ls      <= 1'b1;
                        r_cnt     <= w_cnt_inc;
                        if (w_starved) r_state <= FORCE;
                    end else begin
                        r_wt_addr <= r_buf_addr;
                        r_wt_data <= r_buf_data;
                        r_ls      <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= IDLE;
                    end
                end
                FORCE: begin
                    // WB is stalled this cycle, so the buffer owns the port.
                    r_wt_addr <= r_buf_addr;
                    r_wt_data <= r_buf_data;
                    r_ls      <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected register-file writes are queued as stimulus
// is driven and retired in order by a write-port monitor.
module tb_regfile_wb_arbiter;
    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        pipe_stall;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [31:0] busy_mask;
    logic [4:0]  rf_wt_addr;
    logic [31:0] rf_wt_data;
    logic        rf_L_S;

    int n_vec = 0;
    int n_bad = 0;
    logic [36:0] exp_q[$];

    regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .pipe_stall (pipe_stall),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_addr    (lu_addr),
        .lu_data    (lu_data),
        .iss_valid  (iss_valid),
        .iss_addr   (iss_addr),
        .busy_mask  (busy_mask),
        .rf_wt_addr (rf_wt_addr),
        .rf_wt_data (rf_wt_data),
        .rf_L_S     (rf_L_S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic idle_inputs();
        wb_valid  = 1'b0; wb_addr  = '0; wb_data = '0;
        lu_valid  = 1'b0; lu_addr  = '0; lu_data = '0;
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    // Retire one expected write for every cycle the port is enabled.
    always @(negedge clk) begin
        if (rf_L_S === 1'b1) begin
            check("wr_addr_nonzero", 32'(rf_wt_addr != 5'd0), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_wr_addr", 32'(rf_wt_addr), 32'h0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(rf_wt_addr), 32'(e[36:32]));
                check("wr_data", rf_wt_data, e[31:0]);
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        check("rst_ls", 32'(rf_L_S), 32'd0);
        check("rst_addr", 32'(rf_wt_addr), 32'd0);
        check("rst_data", rf_wt_data, 32'd0);
        check("rst_busy", busy_mask, 32'd0);
        check("rst_ready", 32'(lu_ready), 32'd1);
        check("rst_stall", 32'(pipe_stall), 32'd0);
        rst = 1'b0;

        // Direct LU write clears the busy bit set at issue.
        iss_valid = 1'b1; iss_addr = 5'd5;
        tick();
        idle_inputs();
        check("t1_busy_set", busy_mask, 32'h0000_0020);
        lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'hA5A5_A5A5;
        expect_wr(5'd5, 32'hA5A5_A5A5);
        tick();
        idle_inputs();
        check("t1_busy_clr", busy_mask, 32'd0);
        check("t1_ready", 32'(lu_ready), 32'd1);

        // Collision: WB first, LU buffered then drained.
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h22;
        iss_valid = 1'b1; iss_addr = 5'd7;
        expect_wr(5'd3, 32'h11);
        tick();
        idle_inputs();
        check("t2_ready_low", 32'(lu_ready), 32'd0);
        check("t2_stall", 32'(pipe_stall), 32'd0);
        check("t2_busy7", busy_mask, 32'h0000_0080);
        expect_wr(5'd7, 32'h22);
        tick();
        check("t2_ready_back", 32'(lu_ready), 32'd1);
        check("t2_busy_clr", busy_mask, 32'd0);

        // Starvation: four WB wins, one forced drain, then the held WB write.
        for (int c = 0; c < 6; c++) begin
            int k;
            k = (c == 5) ? 4 : c;
            wb_valid = 1'b1; wb_addr = 5'(16 + k); wb_data = 32'h1000 + 32'(k);
            if (c == 0) begin
                lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'hC0C0_C0C0;
                iss_valid = 1'b1; iss_addr = 5'd12;
            end
            check($sformatf("t3_stall_c%0d", c), 32'(pipe_stall), 32'(c == 4));
            if (c == 4) expect_wr(5'd12, 32'hC0C0_C0C0);
            else        expect_wr(5'(16 + k), 32'h1000 + 32'(k));
            tick();
            idle_inputs();
        end
        check("t3_busy_clr", busy_mask, 32'd0);
        check("t3_ready", 32'(lu_ready), 32'd1);

        // Same-edge set and drain on r9: set wins; issue to r0 is ignored.
        wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h99;
        iss_valid = 1'b1; iss_addr = 5'd9;
        expect_wr(5'd1, 32'h55);
        tick();
        idle_inputs();
        iss_valid = 1'b1; iss_addr = 5'd9;
        expect_wr(5'd9, 32'h99);
        tick();
        idle_inputs();
        check("t4_set_wins", busy_mask, 32'h0000_0200);
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h9A;
        expect_wr(5'd9, 32'h9A);
        tick();
        idle_inputs();
        check("t4_busy_clr", busy_mask, 32'd0);
        iss_valid = 1'b1; iss_addr = 5'd0;
        tick();
        idle_inputs();
        check("t4_r0_issue", busy_mask, 32'd0);

        // WB to r0 counts as no request, so the buffer drains.
        wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h202;
        lu_valid = 1'b1; lu_addr = 5'd14; lu_data = 32'hEE;
        expect_wr(5'd2, 32'h202);
        tick();
        idle_inputs();
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        expect_wr(5'd14, 32'hEE);
        tick();
        idle_inputs();
        check("t5_ready", 32'(lu_ready), 32'd1);
        lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hBAD0;
        tick();
        idle_inputs();
        check("t5_r0_discard", 32'(lu_ready), 32'd1);

        // Reset while in FORCE drops the buffered result.
        for (int c = 0; c < 4; c++) begin
            wb_valid = 1'b1; wb_addr = 5'(24 + c); wb_data = 32'h2400 + 32'(c);
            if (c == 0) begin
                lu_valid = 1'b1; lu_addr = 5'd20; lu_data = 32'h2020;
                iss_valid = 1'b1; iss_addr = 5'd20;
            end
            expect_wr(5'(24 + c), 32'h2400 + 32'(c));
            tick();
            idle_inputs();
        end
        check("t6_in_force", 32'(pipe_stall), 32'd1);
        check("t6_busy20", busy_mask, 32'h0010_0000);
        rst = 1'b1;
        tick();
        check("t6_stall", 32'(pipe_stall), 32'd0);
        check("t6_ls", 32'(rf_L_S), 32'd0);
        check("t6_busy", busy_mask, 32'd0);
        check("t6_ready", 32'(lu_ready), 32'd1);
        rst = 1'b0;
        tick(); tick();
        check("q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
